// File: rtl/l2_arbiter.sv
// rtl/l2_arbiter.sv - two-port (data/instruction) arbiter in front of the L2 cache
//
// Ports:
//   i_clock, i_reset          sole clock, synchronous active-high reset
//   port A (data)             i_a_rw, i_a_request, o_a_ready, i_a_address, o_a_rdata, i_a_wdata
//   port B (instruction)      i_b_rw, i_b_request, o_b_ready, i_b_address, o_b_rdata, i_b_wdata
//   downstream (L2 cache)     o_l2_rw, o_l2_request, i_l2_ready, o_l2_address, i_l2_rdata, o_l2_wdata
// Parameter FIXED_PRIORITY: 0 = round-robin on ties, 1 = port A always wins ties.
// All outputs are registered.

module l2_arbiter #(
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic        i_clock,
    input  logic        i_reset,
    // port A
    input  logic        i_a_rw,
    input  logic        i_a_request,
    output logic        o_a_ready,
    input  logic [31:0] i_a_address,
    output logic [31:0] o_a_rdata,
    input  logic [31:0] i_a_wdata,
    // port B
    input  logic        i_b_rw,
    input  logic        i_b_request,
    output logic        o_b_ready,
    input  logic [31:0] i_b_address,
    output logic [31:0] o_b_rdata,
    input  logic [31:0] i_b_wdata,
    // downstream
    output logic        o_l2_rw,
    output logic        o_l2_request,
    input  logic        i_l2_ready,
    output logic [31:0] o_l2_address,
    input  logic [31:0] i_l2_rdata,
    output logic [31:0] o_l2_wdata
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_A  = 2'd1,
        ST_BUSY_B  = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        last_b_q, last_b_d;        // 1 when B was the most recent grant
    logic        l2_rw_q, l2_rw_d;
    logic        l2_request_q, l2_request_d;
    logic [31:0] l2_address_q, l2_address_d;
    logic [31:0] l2_wdata_q, l2_wdata_d;
    logic        a_ready_q, a_ready_d;
    logic        b_ready_q, b_ready_d;
    logic [31:0] a_rdata_q, a_rdata_d;
    logic [31:0] b_rdata_q, b_rdata_d;
    logic        pick_a;

    // A wins when it is alone, or on a tie when priority is fixed or B went last.
    assign pick_a = i_a_request & (~i_b_request | FIXED_PRIORITY | last_b_q);

    always_comb begin
        state_d      = state_q;
        last_b_d     = last_b_q;
        l2_rw_d      = l2_rw_q;
        l2_request_d = l2_request_q;
        l2_address_d = l2_address_q;
        l2_wdata_d   = l2_wdata_q;
        a_ready_d    = a_ready_q;
        b_ready_d    = b_ready_q;
        a_rdata_d    = a_rdata_q;
        b_rdata_d    = b_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_a) begin
                    l2_rw_d      = i_a_rw;
                    l2_address_d = i_a_address;
                    l2_wdata_d   = i_a_wdata;
                    l2_request_d = 1'b1;
                    last_b_d     = 1'b0;
                    state_d      = ST_BUSY_A;
                end else if (i_b_request) begin
                    l2_rw_d      = i_b_rw;
                    l2_address_d = i_b_address;
                    l2_wdata_d   = i_b_wdata;
                    l2_request_d = 1'b1;
                    last_b_d     = 1'b1;
                    state_d      = ST_BUSY_B;
                end
            end
            ST_BUSY_A: begin
                if (i_l2_ready) begin
                    a_ready_d = 1'b1;
                    // o_l2_rw still holds the granted direction here
                    if (!l2_rw_q) begin
                        a_rdata_d = i_l2_rdata;
                    end
                    l2_request_d = 1'b0;
                    l2_rw_d      = 1'b0;
                    state_d      = ST_RELEASE;
                end
            end
            ST_BUSY_B: begin
                if (i_l2_ready) begin
                    b_ready_d = 1'b1;
                    if (!l2_rw_q) begin
                        b_rdata_d = i_l2_rdata;
                    end
                    l2_request_d = 1'b0;
                    l2_rw_d      = 1'b0;
                    state_d      = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                // One dead cycle: the L2 ignores requests while its ready is high.
                a_ready_d = 1'b0;
                b_ready_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            last_b_q     <= 1'b1;           // A wins the first tie after reset
            l2_rw_q      <= 1'b0;
            l2_request_q <= 1'b0;
            l2_address_q <= 32'd0;
            l2_wdata_q   <= 32'd0;
            a_ready_q    <= 1'b0;
            b_ready_q    <= 1'b0;
            a_rdata_q    <= 32'd0;
            b_rdata_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            last_b_q     <= last_b_d;
            l2_rw_q      <= l2_rw_d;
            l2_request_q <= l2_request_d;
            l2_address_q <= l2_address_d;
            l2_wdata_q   <= l2_wdata_d;
            a_ready_q    <= a_ready_d;
            b_ready_q    <= b_ready_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
        end
    end

    assign o_l2_rw      = l2_rw_q;
    assign o_l2_request = l2_request_q;
    assign o_l2_address = l2_address_q;
    assign o_l2_wdata   = l2_wdata_q;
    assign o_a_ready    = a_ready_q;
    assign o_b_ready    = b_ready_q;
    assign o_a_rdata    = a_rdata_q;
    assign o_b_rdata    = b_rdata_q;

endmodule

// File: tb/tb_l2_arbiter.sv
// tb/tb_l2_arbiter.sv - self-checking bench for l2_arbiter (round-robin and fixed-priority instances)

module tb_l2_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // index 0: round-robin instance, index 1: fixed-priority instance
    logic        rst[2];
    logic        a_rw[2], a_req[2], b_rw[2], b_req[2], l2_ready[2];
    logic [31:0] a_addr[2], a_wdata[2], b_addr[2], b_wdata[2], l2_rdata[2];
    logic        a_ready[2], b_ready[2], l2_rw[2], l2_req[2];
    logic [31:0] a_rdata[2], b_rdata[2], l2_addr[2], l2_wdata[2];

    int tests_run    = 0;
    int tests_failed = 0;

    l2_arbiter #(.FIXED_PRIORITY(1'b0)) u_rr (
        .i_clock(clk), .i_reset(rst[0]),
        .i_a_rw(a_rw[0]), .i_a_request(a_req[0]), .o_a_ready(a_ready[0]),
        .i_a_address(a_addr[0]), .o_a_rdata(a_rdata[0]), .i_a_wdata(a_wdata[0]),
        .i_b_rw(b_rw[0]), .i_b_request(b_req[0]), .o_b_ready(b_ready[0]),
        .i_b_address(b_addr[0]), .o_b_rdata(b_rdata[0]), .i_b_wdata(b_wdata[0]),
        .o_l2_rw(l2_rw[0]), .o_l2_request(l2_req[0]), .i_l2_ready(l2_ready[0]),
        .o_l2_address(l2_addr[0]), .i_l2_rdata(l2_rdata[0]), .o_l2_wdata(l2_wdata[0])
    );

    l2_arbiter #(.FIXED_PRIORITY(1'b1)) u_fp (
        .i_clock(clk), .i_reset(rst[1]),
        .i_a_rw(a_rw[1]), .i_a_request(a_req[1]), .o_a_ready(a_ready[1]),
        .i_a_address(a_addr[1]), .o_a_rdata(a_rdata[1]), .i_a_wdata(a_wdata[1]),
        .i_b_rw(b_rw[1]), .i_b_request(b_req[1]), .o_b_ready(b_ready[1]),
        .i_b_address(b_addr[1]), .o_b_rdata(b_rdata[1]), .i_b_wdata(b_wdata[1]),
        .o_l2_rw(l2_rw[1]), .o_l2_request(l2_req[1]), .i_l2_ready(l2_ready[1]),
        .o_l2_address(l2_addr[1]), .i_l2_rdata(l2_rdata[1]), .o_l2_wdata(l2_wdata[1])
    );

    // Transaction-level reference: phase 0 = free (next edge may grant),
    // 1 = a transaction is outstanding, 2 = the dead cycle after completion.
    int          m_phase[2];
    int          m_port[2];          // 0 = A, 1 = B
    logic        m_last_b[2];
    logic        m_req[2], m_rw[2], m_ar[2], m_br[2];
    logic [31:0] m_addr[2], m_wdata[2], m_ardata[2], m_brdata[2];

    function automatic logic [131:0] dut_vec(input int d);
        return {l2_req[d], l2_rw[d], l2_addr[d], l2_wdata[d],
                a_ready[d], b_ready[d], a_rdata[d], b_rdata[d]};
    endfunction

    function automatic logic [131:0] exp_vec(input int d);
        return {m_req[d], m_rw[d], m_addr[d], m_wdata[d],
                m_ar[d], m_br[d], m_ardata[d], m_brdata[d]};
    endfunction

    task automatic model_update(input int d);
        int take;
        take = -1;
        if (rst[d]) begin
            m_phase[d] = 0; m_last_b[d] = 1'b1;
            m_req[d] = 1'b0; m_rw[d] = 1'b0; m_addr[d] = '0; m_wdata[d] = '0;
            m_ar[d] = 1'b0; m_br[d] = 1'b0; m_ardata[d] = '0; m_brdata[d] = '0;
        end else if (m_phase[d] == 0) begin
            if (a_req[d] && b_req[d]) begin
                if (d == 1)           take = 0;
                else if (m_last_b[d]) take = 0;
                else                  take = 1;
            end else if (a_req[d]) begin
                take = 0;
            end else if (b_req[d]) begin
                take = 1;
            end
            if (take == 0) begin
                m_rw[d] = a_rw[d]; m_addr[d] = a_addr[d]; m_wdata[d] = a_wdata[d];
            end else if (take == 1) begin
                m_rw[d] = b_rw[d]; m_addr[d] = b_addr[d]; m_wdata[d] = b_wdata[d];
            end
            if (take >= 0) begin
                m_req[d] = 1'b1; m_port[d] = take; m_last_b[d] = (take == 1); m_phase[d] = 1;
            end
        end else if (m_phase[d] == 1) begin
            if (l2_ready[d]) begin
                if (m_port[d] == 0) begin
                    m_ar[d] = 1'b1;
                    if (!m_rw[d]) m_ardata[d] = l2_rdata[d];
                end else begin
                    m_br[d] = 1'b1;
                    if (!m_rw[d]) m_brdata[d] = l2_rdata[d];
                end
                m_req[d] = 1'b0; m_rw[d] = 1'b0; m_phase[d] = 2;
            end
        end else begin
            m_ar[d] = 1'b0; m_br[d] = 1'b0; m_phase[d] = 0;
        end
    endtask

    // One clock: the model consumes the inputs seen at the edge, outputs are sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        model_update(0);
        model_update(1);
        @(negedge clk);
    endtask

    task automatic clear_inputs(input int d);
        a_rw[d] = 1'b0; a_req[d] = 1'b0; a_addr[d] = '0; a_wdata[d] = '0;
        b_rw[d] = 1'b0; b_req[d] = 1'b0; b_addr[d] = '0; b_wdata[d] = '0;
        l2_ready[d] = 1'b0; l2_rdata[d] = '0;
    endtask

    task automatic do_reset(input int d);
        clear_inputs(d);
        rst[d] = 1'b1;
        tick();
        rst[d] = 1'b0;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; a_req[d] = 1'b1; b_req[d] = 1'b1; l2_ready[d] = 1'b1;
            a_addr[d] = 32'hFFFF_FFFF; l2_rdata[d] = 32'hFFFF_FFFF;
        end
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            tests_run++;
            if (dut_vec(d) !== '0) begin
                tests_failed++;
                $display("FAIL reset_state inst=%0d got=%h exp=0", d, dut_vec(d));
            end
            clear_inputs(d);
            rst[d] = 1'b0;
        end
    endtask

    task automatic test_a_read();
        do_reset(0);
        a_req[0] = 1'b1; a_rw[0] = 1'b0; a_addr[0] = 32'h0000_1000; a_wdata[0] = 32'h5555_5555;
        tick();
        tests_run++;
        if ({l2_req[0], l2_rw[0], l2_addr[0]} !== {1'b1, 1'b0, 32'h0000_1000}) begin
            tests_failed++;
            $display("FAIL a_read_grant got=%b/%b/%h exp=1/0/00001000", l2_req[0], l2_rw[0], l2_addr[0]);
        end
        tick();
        tick();
        tests_run++;
        if ({l2_req[0], a_ready[0], l2_addr[0]} !== {1'b1, 1'b0, 32'h0000_1000}) begin
            tests_failed++;
            $display("FAIL a_read_hold got=%b/%b/%h exp=1/0/00001000", l2_req[0], a_ready[0], l2_addr[0]);
        end
        l2_ready[0] = 1'b1; l2_rdata[0] = 32'hDEAD_BEEF;
        tick();
        l2_ready[0] = 1'b0; a_req[0] = 1'b0;
        tests_run++;
        if ({a_ready[0], b_ready[0], l2_req[0], a_rdata[0]} !== {3'b100, 32'hDEAD_BEEF}) begin
            tests_failed++;
            $display("FAIL a_read_done got=%b%b%b/%h exp=100/deadbeef", a_ready[0], b_ready[0], l2_req[0], a_rdata[0]);
        end
        tick();
        tests_run++;
        if ({a_ready[0], b_ready[0], l2_req[0]} !== 3'b000) begin
            tests_failed++;
            $display("FAIL a_read_release got=%b%b%b exp=000", a_ready[0], b_ready[0], l2_req[0]);
        end
    endtask

    task automatic test_tie_rr();
        logic [31:0] grants[$];
        logic prev_req;
        bit a_done, b_done;
        do_reset(0);
        a_req[0] = 1'b1; a_addr[0] = 32'h0000_0A00;
        b_req[0] = 1'b1; b_addr[0] = 32'h0000_0B00;
        prev_req = 1'b0; a_done = 0; b_done = 0;
        for (int cyc = 0; cyc < 40 && !(a_done && b_done); cyc++) begin
            tick();
            if (l2_req[0] && !prev_req) grants.push_back(l2_addr[0]);
            prev_req = l2_req[0];
            if (a_ready[0]) begin a_req[0] = 1'b0; a_done = 1; end
            if (b_ready[0]) begin b_req[0] = 1'b0; b_done = 1; end
            l2_ready[0] = l2_req[0];
            l2_rdata[0] = $urandom;
        end
        l2_ready[0] = 1'b0;
        tick();
        tests_run++;
        if (grants.size() !== 2) begin
            tests_failed++;
            $display("FAIL tie_rr_count got=%0d exp=2", grants.size());
        end else begin
            tests_run++;
            if ({grants[0], grants[1]} !== {32'h0000_0A00, 32'h0000_0B00}) begin
                tests_failed++;
                $display("FAIL tie_rr_order got=%h,%h exp=00000a00,00000b00", grants[0], grants[1]);
            end
        end
    endtask

    // Both ports keep a request up at all times; grant order is read from address bit 31.
    task automatic run_contention(input int d, input int a_limit, output int order[$]);
        logic prev_req;
        int   a_count;
        do_reset(d);
        a_req[d] = 1'b1; a_addr[d] = {1'b0, 31'($urandom)}; a_wdata[d] = $urandom; a_rw[d] = ($urandom_range(1, 0) == 1);
        b_req[d] = 1'b1; b_addr[d] = {1'b1, 31'($urandom)}; b_wdata[d] = $urandom; b_rw[d] = ($urandom_range(1, 0) == 1);
        prev_req = 1'b0; a_count = 0;
        for (int cyc = 0; cyc < 400 && order.size() < 16; cyc++) begin
            tick();
            if (l2_req[d] && !prev_req) order.push_back(l2_addr[d][31] ? 1 : 0);
            prev_req = l2_req[d];
            if (a_ready[d]) begin
                a_count++;
                if (a_count >= a_limit) a_req[d] = 1'b0;
                a_addr[d] = {1'b0, 31'($urandom)}; a_rw[d] = ($urandom_range(1, 0) == 1);
            end
            if (b_ready[d]) begin
                b_addr[d] = {1'b1, 31'($urandom)}; b_rw[d] = ($urandom_range(1, 0) == 1);
            end
            l2_ready[d] = l2_req[d] && ($urandom_range(1, 0) == 1);
            l2_rdata[d] = $urandom;
        end
        do_reset(d);
    endtask

    task automatic test_fairness();
        int order[$];
        run_contention(0, 1000, order);
        tests_run++;
        if (order.size() !== 16) begin
            tests_failed++;
            $display("FAIL fairness_count got=%0d exp=16", order.size());
        end
        for (int i = 0; i < order.size(); i++) begin
            tests_run++;
            if (order[i] !== (i % 2)) begin
                tests_failed++;
                $display("FAIL fairness_grant idx=%0d got=%0d exp=%0d", i, order[i], i % 2);
            end
        end
    endtask

    task automatic test_fixed_priority();
        int order[$];
        run_contention(1, 5, order);
        tests_run++;
        if (order.size() !== 16) begin
            tests_failed++;
            $display("FAIL fixed_count got=%0d exp=16", order.size());
        end
        for (int i = 0; i < order.size(); i++) begin
            tests_run++;
            if (order[i] !== ((i < 5) ? 0 : 1)) begin
                tests_failed++;
                $display("FAIL fixed_grant idx=%0d got=%0d exp=%0d", i, order[i], (i < 5) ? 0 : 1);
            end
        end
    endtask

    task automatic test_b_write();
        do_reset(0);
        b_req[0] = 1'b1; b_rw[0] = 1'b0; b_addr[0] = 32'h0000_2000;
        tick();
        l2_ready[0] = 1'b1; l2_rdata[0] = 32'hCAFE_F00D;
        tick();
        l2_ready[0] = 1'b0; b_req[0] = 1'b0;
        tick();
        tests_run++;
        if (b_rdata[0] !== 32'hCAFE_F00D) begin
            tests_failed++;
            $display("FAIL b_seed_read got=%h exp=cafef00d", b_rdata[0]);
        end
        b_req[0] = 1'b1; b_rw[0] = 1'b1; b_addr[0] = 32'h0000_2004; b_wdata[0] = 32'h1234_5678;
        tick();
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if ({l2_req[0], l2_rw[0], l2_addr[0], l2_wdata[0], b_ready[0]} !==
                {1'b1, 1'b1, 32'h0000_2004, 32'h1234_5678, 1'b0}) begin
                tests_failed++;
                $display("FAIL b_write_hold k=%0d got=%b/%b/%h/%h exp=1/1/00002004/12345678",
                         k, l2_req[0], l2_rw[0], l2_addr[0], l2_wdata[0]);
            end
            if (k < 3) tick();
        end
        l2_ready[0] = 1'b1; l2_rdata[0] = 32'hBAD0_BAD0;
        tick();
        l2_ready[0] = 1'b0; b_req[0] = 1'b0;
        tests_run++;
        if ({b_ready[0], a_ready[0], l2_req[0], l2_rw[0], b_rdata[0]} !== {4'b1000, 32'hCAFE_F00D}) begin
            tests_failed++;
            $display("FAIL b_write_done got=%b%b%b%b/%h exp=1000/cafef00d", b_ready[0], a_ready[0], l2_req[0], l2_rw[0], b_rdata[0]);
        end
        tick();
        tests_run++;
        if (b_ready[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL b_write_pulse got=%b exp=0", b_ready[0]);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        do_reset(0);
        a_req[0] = 1'b1; a_rw[0] = 1'b0; a_addr[0] = 32'h0000_3000;
        tick();
        tick();
        rst[0] = 1'b1; l2_ready[0] = 1'b1; l2_rdata[0] = 32'h1111_1111;
        tick();
        rst[0] = 1'b0; l2_ready[0] = 1'b0; a_req[0] = 1'b0;
        tests_run++;
        if ({l2_req[0], a_ready[0], a_rdata[0]} !== 34'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_abort got=%b/%b/%h exp=0/0/0", l2_req[0], a_ready[0], a_rdata[0]);
        end
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (a_ready[0] || l2_req[0]) seen = 1;
        end
        tests_run++;
        if (seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_quiet got=%b exp=0", seen);
        end
        a_req[0] = 1'b1; a_addr[0] = 32'h0000_3004;
        tick();
        tests_run++;
        if ({l2_req[0], l2_addr[0]} !== {1'b1, 32'h0000_3004}) begin
            tests_failed++;
            $display("FAIL reset_mid_regrant got=%b/%h exp=1/00003004", l2_req[0], l2_addr[0]);
        end
        l2_ready[0] = 1'b1; l2_rdata[0] = 32'h0BAD_F00D;
        tick();
        l2_ready[0] = 1'b0; a_req[0] = 1'b0;
        tests_run++;
        if ({a_ready[0], a_rdata[0]} !== {1'b1, 32'h0BAD_F00D}) begin
            tests_failed++;
            $display("FAIL reset_mid_fresh got=%b/%h exp=1/0badf00d", a_ready[0], a_rdata[0]);
        end
        tick();
    endtask

    task automatic test_random();
        bit pa[2];
        bit pb[2];
        for (int d = 0; d < 2; d++) begin
            clear_inputs(d);
            rst[d] = 1'b1;
            pa[d] = 0; pb[d] = 0;
        end
        tick();
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int d = 0; d < 2; d++) begin
                if (a_ready[d]) pa[d] = 0;
                if (b_ready[d]) pb[d] = 0;
                rst[d] = ($urandom_range(149, 0) == 0);
                if (rst[d]) begin pa[d] = 0; pb[d] = 0; end
                if (!pa[d] && $urandom_range(2, 0) == 0) begin
                    pa[d] = 1; a_rw[d] = ($urandom_range(1, 0) == 1); a_addr[d] = $urandom; a_wdata[d] = $urandom;
                end
                if (!pb[d] && $urandom_range(2, 0) == 0) begin
                    pb[d] = 1; b_rw[d] = ($urandom_range(1, 0) == 1); b_addr[d] = $urandom; b_wdata[d] = $urandom;
                end
                a_req[d] = pa[d];
                b_req[d] = pb[d];
                // ready noise outside a transaction must be ignored
                l2_ready[d] = l2_req[d] ? ($urandom_range(2, 0) == 0) : ($urandom_range(1, 0) == 1);
                l2_rdata[d] = $urandom;
            end
            tick();
            for (int d = 0; d < 2; d++) begin
                tests_run++;
                if (dut_vec(d) !== exp_vec(d)) begin
                    tests_failed++;
                    $display("FAIL random_model inst=%0d cyc=%0d got=%h exp=%h", d, cyc, dut_vec(d), exp_vec(d));
                end
                tests_run++;
                if ({a_ready[d], b_ready[d]} === 2'b11) begin
                    tests_failed++;
                    $display("FAIL random_ready_excl inst=%0d cyc=%0d got=11 exp=not 11", d, cyc);
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            clear_inputs(d);
            rst[d] = 1'b0;
        end
        tick();
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            clear_inputs(d);
            rst[d] = 1'b1;
            m_phase[d] = 0; m_port[d] = 0; m_last_b[d] = 1'b1;
            m_req[d] = 1'b0; m_rw[d] = 1'b0; m_ar[d] = 1'b0; m_br[d] = 1'b0;
            m_addr[d] = '0; m_wdata[d] = '0; m_ardata[d] = '0; m_brdata[d] = '0;
        end
        @(negedge clk);
        test_reset();
        test_a_read();
        test_tie_rr();
        test_fairness();
        test_fixed_priority();
        test_b_write();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/l2_arbiter.md
L2_ARBITER -- requirements
Module: l2_arbiter

Interface
REQ-001 Parameter FIXED_PRIORITY, default 0: 0 selects round-robin arbitration, 1 gives port A priority on every tie.
REQ-002 Reset is synchronous and active-high; the block uses one clock.
REQ-003 i_clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 i_reset  input  1  synchronous active-high reset.
REQ-005 Port A (data requester), in order: i_a_rw in 1 (1=write); i_a_request in 1; o_a_ready out 1; i_a_address in 32; o_a_rdata out 32; i_a_wdata in 32.
REQ-006 Port B (instruction requester): i_b_rw, i_b_request, o_b_ready, i_b_address, o_b_rdata, i_b_wdata; directions and widths are identical to port A.
REQ-007 Downstream port (to the L2 cache): o_l2_rw out 1; o_l2_request out 1; i_l2_ready in 1; o_l2_address out 32; i_l2_rdata in 32; o_l2_wdata out 32.
REQ-008 Every output is registered.

Function
REQ-009 States: IDLE, BUSY_A, BUSY_B, RELEASE; encoding is free; any unused encoding goes to IDLE on the next cycle.
REQ-010 The arbiter samples requests only in IDLE.
REQ-011 IDLE, exactly one port requesting: grant that port and go to BUSY_A or BUSY_B.
REQ-012 IDLE, both ports requesting, FIXED_PRIORITY=0: grant the port that was not granted last.
REQ-013 IDLE, both ports requesting, FIXED_PRIORITY=1: grant A.
REQ-014 Grant edge: copy the granted port's rw, address and wdata into o_l2_rw, o_l2_address and o_l2_wdata, set o_l2_request=1, and record that port as last granted.
REQ-015 Latency: o_l2_request is high in the first cycle after the request was sampled in IDLE.
REQ-016 BUSY_x: the downstream outputs stay stable until i_l2_ready is sampled high; the granted port's address and wdata are not re-sampled.
REQ-017 BUSY_x with i_l2_ready=1, in the same edge: o_x_ready=1; o_x_rdata=i_l2_rdata on a read, previous value kept on a write; o_l2_request=0; o_l2_rw=0; state goes to RELEASE.
REQ-018 RELEASE lasts exactly one cycle: clear o_a_ready and o_b_ready, make no grant, go to IDLE.
REQ-019 RELEASE exists because the downstream ignores requests while its own ready is high.
REQ-020 o_x_ready is a single-cycle pulse, once per granted transaction; o_a_ready and o_b_ready are never high together.
REQ-021 Requester contract: hold request, rw, address and wdata stable until its ready pulse.
REQ-022 A requester may drop its request, or present a new one, on the edge that ends its ready cycle.
REQ-023 A request held high through RELEASE is treated as a new transaction in the following IDLE.
REQ-024 A request is never lost: a waiting port is granted at the next IDLE.
REQ-025 With FIXED_PRIORITY=0 the worst-case wait is one full transaction of the other port.
REQ-026 The non-granted port's o_ready stays 0 and its o_rdata is unchanged.
REQ-027 i_l2_ready is ignored in IDLE and RELEASE.
REQ-028 Minimum transaction period per port: 3 cycles plus downstream latency (grant, busy, release).

Reset
REQ-029 While i_reset=1 at a rising edge: state=IDLE; o_l2_request=0; o_l2_rw=0; o_l2_address=0; o_l2_wdata=0; o_a_ready=0; o_b_ready=0; o_a_rdata=0; o_b_rdata=0; last granted=B, so A wins the first tie.
REQ-030 Reset during BUSY_x abandons the transaction: no ready pulse is issued, and o_l2_request is 0 in the cycle after the reset edge.
REQ-031 Requests are sampled again from the first edge at which i_reset=0.

Verification
REQ-032 A-only read: i_a_request=1, rw=0, addr 0x0000_1000; downstream ready after 2 cycles with rdata 0xDEAD_BEEF -> o_l2_address=0x0000_1000, then o_a_ready pulses 1 cycle with o_a_rdata=0xDEAD_BEEF, and o_b_ready stays 0.
REQ-033 Tie, FIXED_PRIORITY=0: A and B request simultaneously after reset -> A granted first; B granted in the IDLE after A's RELEASE; o_l2_address shows A's address, then B's.
REQ-034 Fairness: A and B request continuously for 8 transactions each -> grants strictly alternate A,B,A,B.
REQ-035 Tie, FIXED_PRIORITY=1: continuous A requests -> B is granted only when A drops its request.
REQ-036 B write: rw=1, addr 0x0000_2004, wdata 0x1234_5678 -> o_l2_rw=1 and o_l2_wdata=0x1234_5678 until i_l2_ready; o_b_ready pulses once; o_b_rdata is unchanged.
REQ-037 Reset mid-transaction: i_reset=1 during BUSY_A -> the next cycle shows o_l2_request=0 and no o_a_ready pulse ever; a fresh A request after reset completes normally.
